apb_requester_engine: RTL and testbench

- Single-outstanding APB requester (initiator) that turns a valid/ready command stream into APB setup/access transfers and returns the result on a valid/ready response stream.
- Sits between a management CPU or a debug/UART bridge and the APB fabric that hosts completer blocks such as the device info block.
- Adds a bounded wait on pready, so a hung completer can never stall the requester.

---
 rtl/apb_requester_pkg.sv | 24 ++
 rtl/apb_if.sv | 29 ++
 rtl/apb_requester_engine.sv | 197 +++++++++++++++++++
 tb/tb_apb_requester_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_requester_pkg.sv
// Shared types for the APB requester engine and the bridge front-ends that feed it.
package apb_requester_pkg;

  // The engine only handles 32-bit APB data.
  localparam int APB_DATA_WIDTH = 32;

  // Transfer sequencing states. The values are fixed so debug tools can decode them.
  typedef enum logic [1:0] {
    IDLE   = 2'h0,
    SETUP  = 2'h1,
    ACCESS = 2'h2,
    RESP   = 2'h3
  } state_e;

  // Response payload returned to the command source.
  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } resp_t;

  localparam resp_t RESP_CLEAR = '{rdata: '0, err: 1'b0, timeout: 1'b0};

endpackage

// File: rtl/apb_if.sv
// APB bus bundle. pclk must be the requester's own clock.
interface apb_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic pclk
);

  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport requester (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport completer (
    input  pclk, paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_requester_engine.sv
// Single-outstanding APB requester: command stream in, APB setup/access out,
// response stream back, with a bounded wait on pready.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready are
// both high. A producer holds valid and its payload stable until that edge;
// ready may be used by the consumer freely. Here cmd_ready is high only in
// IDLE, and resp_valid plus every resp_* field stays frozen until resp_ready.
module apb_requester_engine
  import apb_requester_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output state_e                dbg_state,
  apb_if.requester              apb
);

  // Elaboration guards on parameters the datapath cannot support.
  if (DATA_WIDTH != APB_DATA_WIDTH) begin : g_bad_data_width
    $error("apb_requester_engine: DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_requester_engine: TIMEOUT_CYCLES must be in 1..65535");
  end

  // Wait counter is just wide enough to hold TIMEOUT_CYCLES.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_psel;
  logic                  r_penable;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_accept;
  logic                  w_timeout_hit;
  logic                  r_resp_valid;
  resp_t                 r_resp;

  // A command is taken only while the registered ready is up, which implies IDLE.
  assign w_accept = cmd_valid && r_cmd_ready;

  // Saturating increment so the counter can never wrap back to zero.
  assign w_cnt_inc = (r_wait_cnt == TO_LIM) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

  // Abort when this non-ready cycle is the TIMEOUT_CYCLES-th one; a pready
  // arriving on that same cycle takes priority in the state logic.
  assign w_timeout_hit = !apb.pready && (w_cnt_inc == TO_LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode for the IDLE -> SETUP -> ACCESS -> RESP loop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = SETUP;
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (apb.pready || w_timeout_hit) w_state_next = RESP;
      end
      RESP: begin
        if (resp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // cmd_ready is registered from the next state so it is high exactly in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_next == IDLE);
    end
  end

  // APB request signals: latch the command, then walk psel/penable through the phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_paddr   <= cmd_addr;
            r_pwrite  <= cmd_write;
            r_pwdata  <= cmd_wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (apb.pready || w_timeout_hit) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // Wait counter: cleared in SETUP, counts non-ready ACCESS cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if (r_state == ACCESS && !apb.pready) begin
      r_wait_cnt <= w_cnt_inc;
    end
  end

  // Response capture on completion or abort; held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp       <= RESP_CLEAR;
    end else begin
      case (r_state)
        ACCESS: begin
          if (apb.pready) begin
            r_resp_valid   <= 1'b1;
            r_resp.err     <= apb.pslverr;
            r_resp.timeout <= 1'b0;
            r_resp.rdata   <= (r_pwrite || apb.pslverr) ? '0 : apb.prdata;
          end else if (w_timeout_hit) begin
            r_resp_valid   <= 1'b1;
            r_resp.err     <= 1'b1;
            r_resp.timeout <= 1'b1;
            r_resp.rdata   <= '0;
          end
        end
        RESP: begin
          if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: begin
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp.rdata;
  assign resp_err     = r_resp.err;
  assign resp_timeout = r_resp.timeout;
  assign dbg_state    = r_state;

  assign apb.paddr   = r_paddr;
  assign apb.psel    = r_psel;
  assign apb.penable = r_penable;
  assign apb.pwrite  = r_pwrite;
  assign apb.pwdata  = r_pwdata;
  assign apb.pstrb   = '1;

endmodule

// File: tb/tb_apb_requester_engine.sv
// Bench for apb_requester_engine: scratch-register APB completer model,
// directed command vectors, and a response scoreboard.
module tb_apb_requester_engine;
  import apb_requester_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected response: {rdata, err, timeout}
  logic [33:0] exp_q[$];

  // Completer model controls
  logic        hang;
  int          wait_n;
  int          acc_cnt;
  logic [31:0] mem [0:31];
  logic        w_mapped;

  // Bus observation state
  int   run_len;
  int   last_len;
  logic prev_done;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus (.pclk(clk));

  apb_requester_engine #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .resp_timeout(resp_timeout),
    .dbg_state   (dbg_state),
    .apb         (bus)
  );

  // ---------------- completer model ----------------
  assign w_mapped    = (bus.paddr < 16'h0080);
  assign bus.pready  = bus.psel && bus.penable && !hang && (acc_cnt >= wait_n);
  assign bus.prdata  = w_mapped ? mem[bus.paddr[6:2]] : 32'hbad0bad0;
  assign bus.pslverr = bus.pready && !w_mapped;

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && w_mapped)
      mem[bus.paddr[6:2]] <= bus.pwdata;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      run_len   = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.psel && bus.penable) begin
        run_len++;
      end else if (run_len != 0) begin
        last_len = run_len;
        run_len  = 0;
      end
      if (prev_done) chk("psel_gap", {63'd0, bus.psel}, 64'd0);
      prev_done = bus.psel && bus.penable && bus.pready;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {30'd0, resp_rdata, resp_err, resp_timeout}, 64'd0);
        end else begin
          chk("resp", {30'd0, resp_rdata, resp_err, resp_timeout}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [33:0] exp);
    logic got;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("accept", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic got;
    int   bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    resp_ready = 1'b1; hang = 1'b0; wait_n = 0; acc_cnt = 0;
    run_len = 0; last_len = 0; prev_done = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[6] = 32'h5555aaaa;  // address 0x0018

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_resp_err", {62'd0, resp_err, resp_timeout}, 64'd0);
    chk("rst_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd0);
    chk("rst_pwrite", {63'd0, bus.pwrite}, 64'd0);
    chk("rst_paddr", {48'd0, bus.paddr}, 64'd0);
    chk("rst_pwdata", {32'd0, bus.pwdata}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_release_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Zero-wait read of 0x0018 with phase-by-phase waveform checks
    issue(1'b0, 16'h0018, 32'h0, {32'h5555aaaa, 1'b0, 1'b0});
    @(negedge clk);  // after N+1 edge... SETUP phase
    chk("setup_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd2);
    chk("setup_pwrite_paddr", {47'd0, bus.pwrite, bus.paddr}, {47'd0, 1'b0, 16'h0018});
    chk("setup_pstrb", {60'd0, bus.pstrb}, 64'hf);
    @(negedge clk);
    chk("access_psel_penable", {62'd0, bus.psel, bus.penable}, 64'd3);
    chk("access_state", {62'd0, dbg_state}, {62'd0, ACCESS});
    chk("access_no_early_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("n3_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("n3_psel_dropped", {62'd0, bus.psel, bus.penable}, 64'd0);
    wait_idle();

    // Write then read back with wait states
    issue(1'b1, 16'h0018, 32'hdeadbeef, {32'h0, 1'b0, 1'b0});
    wait_idle();
    wait_n = 2;
    issue(1'b0, 16'h0018, 32'h0, {32'hdeadbeef, 1'b0, 1'b0});
    wait_idle();
    wait_n = 0;

    // Unmapped address: completer signals pslverr
    issue(1'b0, 16'h00fc, 32'h0, {32'h0, 1'b1, 1'b0});
    issue(1'b1, 16'h00fc, 32'h11112222, {32'h0, 1'b1, 1'b0});
    wait_idle();

    // Completer never ready: abort after exactly 4 ACCESS cycles
    hang = 1'b1;
    issue(1'b0, 16'h0040, 32'h0, {32'h0, 1'b1, 1'b1});
    wait_idle();
    chk("timeout_access_len", 64'(last_len), 64'd4);
    hang = 1'b0;

    // pready on the 4th ACCESS cycle wins over the timeout
    wait_n = 3;
    issue(1'b0, 16'h0018, 32'h0, {32'hdeadbeef, 1'b0, 1'b0});
    wait_idle();
    chk("edge_access_len", 64'(last_len), 64'd4);
    wait_n = 0;

    // Response backpressure with a pending command
    resp_ready = 1'b0;
    issue(1'b0, 16'h0018, 32'h0, {32'hdeadbeef, 1'b0, 1'b0});
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_resp_seen", {63'd0, got}, 64'd1);
    exp_q.push_back({32'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 32'h12345678;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== 32'hdeadbeef || resp_err || resp_timeout ||
          cmd_ready || bus.psel) bad++;
    end
    chk("bp_hold_stable", 64'(bad), 64'd0);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    chk("bp_release_cmd_ready_high", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_setup", {46'd0, bus.psel, bus.penable, bus.paddr}, {46'd0, 2'b10, 16'h0020});
    wait_idle();

    // Reset in the middle of ACCESS discards the transfer
    hang = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0018;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_mid_accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);  // SETUP
    @(negedge clk);  // ACCESS
    chk("rst_mid_in_access", {62'd0, bus.psel, bus.penable}, 64'd3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus_idle", {61'd0, bus.psel, bus.penable, resp_valid}, 64'd0);
    @(negedge clk);
    chk("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Normal operation after the reset; reads the value written under backpressure
    wait_n = 1;
    issue(1'b0, 16'h0020, 32'h0, {32'h12345678, 1'b0, 1'b0});
    wait_idle();

    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
